// File: rtl/half_adder_pkg.sv
// Shared constants and the per-lane result type for the half-adder datapath.
package half_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  typedef struct packed {
    logic s;
    logic c;
  } lane_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// Purpose: single-bit combinational half adder, s = a ^ b, c = a & b.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// Purpose: registered WIDTH-lane half adder with valid flag; optional carry-event counter under HALF_ADDER_STATS_EN.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; every valid operand is accepted and out_valid pulses once per operand.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
`ifdef HALF_ADDER_STATS_EN
  output logic [CNT_W-1:0] carry_cnt,
`endif
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_param
    $error("half_adder: WIDTH must be 1..64 and CNT_W at least 1");
  end

  lane_t            lane [WIDTH];
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] cout_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (lane[i].s),
      .c (lane[i].c)
    );
    assign sum_nxt[i]  = lane[i].s;
    assign cout_nxt[i] = lane[i].c;
  end

  // Result register only loads on accepted operands, so idle-cycle garbage on a/b never reaches sum/cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_nxt;
        cout <= cout_nxt;
      end
    end
  end

`ifdef HALF_ADDER_STATS_EN
  // Saturating: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (in_valid && (|cout_nxt) && (carry_cnt != {CNT_W{1'b1}})) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Directed self-checking bench: WIDTH=1 instance (CNT_W=2) and WIDTH=4 instance; counter checks with HALF_ADDER_STATS_EN.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [0:0] sum1, cout1;
  logic [3:0] sum4, cout4;
  logic       ov1, ov4;
`ifdef HALF_ADDER_STATS_EN
  logic [1:0]  cnt1;
  logic [15:0] cnt4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a1),
    .b         (b1),
    .sum       (sum1),
    .cout      (cout1),
`ifdef HALF_ADDER_STATS_EN
    .carry_cnt (cnt1),
`endif
    .out_valid (ov1)
  );

  half_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
    .sum       (sum4),
    .cout      (cout4),
`ifdef HALF_ADDER_STATS_EN
    .carry_cnt (cnt4),
`endif
    .out_valid (ov4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, then settle just past the rising edge for sampling.
  task automatic step(input logic r, input logic v, input logic x, input logic y);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a1       = x;
    b1       = y;
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_chk(input string tag, input int exp);
`ifdef HALF_ADDER_STATS_EN
    chk(tag, 64'(cnt1), 64'(exp));
`endif
  endtask

  logic [1:0] vec_sc [4];
  logic [3:0] es, ec;
  logic [1:0] lsum;

  initial begin
    // {cout,sum} for inputs 00,01,10,11
    vec_sc[0] = 2'b00; vec_sc[1] = 2'b01; vec_sc[2] = 2'b01; vec_sc[3] = 2'b10;

    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_sum",  64'(sum1), 64'd0);
    chk("rst_cout", 64'(cout1), 64'd0);
    chk("rst_ov",   64'(ov1), 64'd0);
    chk("rst_ov4",  64'(ov4), 64'd0);
    cnt_chk("rst_cnt", 0);

    // Truth table, back-to-back
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, i[1], i[0]);
      chk($sformatf("tt%0d_sum", i),  64'(sum1),  64'(vec_sc[i][0]));
      chk($sformatf("tt%0d_cout", i), 64'(cout1), 64'(vec_sc[i][1]));
      chk($sformatf("tt%0d_ov", i),   64'(ov1),   64'd1);
    end
    cnt_chk("tt_cnt", 1);

    // Reset overrides a valid (1,1)
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rstv_sum",  64'(sum1), 64'd0);
    chk("rstv_cout", 64'(cout1), 64'd0);
    chk("rstv_ov",   64'(ov1), 64'd0);
    cnt_chk("rstv_cnt", 0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("post_sum",  64'(sum1), 64'd0);
    chk("post_cout", 64'(cout1), 64'd1);
    chk("post_ov",   64'(ov1), 64'd1);

    // Hold while idle, with operands changing underneath
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("hold0_sum", 64'(sum1), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("hold%0d_sum", i + 1),  64'(sum1),  64'd1);
      chk($sformatf("hold%0d_cout", i + 1), 64'(cout1), 64'd0);
      chk($sformatf("hold%0d_ov", i + 1),   64'(ov1),   64'd0);
    end
    cnt_chk("hold_cnt", 1);

    // Counter saturation at CNT_W=2
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      cnt_chk($sformatf("sat%0d_cnt", i), (i > 3) ? 3 : i);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("nc%0d_sum", i), 64'(sum1), 64'd1);
      cnt_chk($sformatf("nc%0d_cnt", i), 3);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    cnt_chk("idle_cnt", 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cnt_chk("clr_cnt", 0);

    // Reset mid-stream drops the in-flight result
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("mid_ov1",  64'(ov1), 64'd1);
    chk("mid_sum1", 64'(sum1), 64'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_ov2",  64'(ov1), 64'd0);
    chk("mid_sum2", 64'(sum1), 64'd0);

    // WIDTH=4 directed vector
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; a1 = '0; b1 = '0;
    a4 = 4'b1100; b4 = 4'b1010;
    @(posedge clk);
    #1;
    chk("w4_sum",  64'(sum4),  64'(4'b0110));
    chk("w4_cout", 64'(cout4), 64'(4'b1000));
    chk("w4_ov",   64'(ov4),   64'd1);

    // WIDTH=4 all operand pairs, expected from per-lane 2-bit addition
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a4 = 4'(i >> 4);
      b4 = 4'(i);
      for (int j = 0; j < 4; j++) begin
        lsum  = 2'(a4[j]) + 2'(b4[j]);
        es[j] = lsum[0];
        ec[j] = lsum[1];
      end
      @(posedge clk);
      #1;
      chk($sformatf("ex%0d_sum", i),  64'(sum4),  64'(es));
      chk($sformatf("ex%0d_cout", i), 64'(cout4), 64'(ec));
      chk($sformatf("ex%0d_ov", i),   64'(ov4),   64'd1);
    end
`ifdef HALF_ADDER_STATS_EN
    // 1 directed + every pair except the 81 with a&b==0 carry: 1 + 175
    chk("ex_cnt4", 64'(cnt4), 64'd176);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_half_adder
